// File: rtl/wb_req_master_pkg.sv
// Shared types and constants for the wb_req_master Wishbone request master.
// Optional watchdog is enabled with WB_MASTER_TIMEOUT_EN.
package wb_req_master_pkg;

   localparam int unsigned WB_DATA_WIDTH = 32;
   localparam int unsigned WB_SEL_WIDTH  = 4;

   localparam int unsigned DEF_MAX_RETRY      = 3;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STROBE,
      ST_WAIT,
      ST_RESP
   } state_e;

endpackage

// File: rtl/wb_req_master_watchdog.sv
// Loadable saturating up-counter with clear, enable and expired flag.
// Used by wb_req_master when WB_MASTER_TIMEOUT_EN is defined.
module wb_req_watchdog #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic [WIDTH-1:0] limit_i,
   output logic             expired_o
);

   logic [WIDTH-1:0] cnt_q;

   assign expired_o = (cnt_q >= limit_i);

   // Stops at the limit so a long idle bus can never wrap the count.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && !expired_o) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/wb_req_master.sv
// Single-outstanding Wishbone B4 pipelined master with bounded retry.
// Define WB_MASTER_TIMEOUT_EN to add the TIMEOUT_CYCLES watchdog.
module wb_req_master
   import wb_req_master_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     req_i,
   input  logic                     req_we_i,
   input  logic [ADDR_WIDTH-1:0]    req_addr_i,
   input  logic [WB_DATA_WIDTH-1:0] req_dat_i,
   input  logic [WB_SEL_WIDTH-1:0]  req_sel_i,
   output logic                     req_rdy_o,
   output logic                     rsp_valid_o,
   output logic [WB_DATA_WIDTH-1:0] rsp_dat_o,
   output logic                     rsp_err_o,
   output logic                     wb_cyc_o,
   output logic                     wb_stb_o,
   output logic [ADDR_WIDTH-1:0]    wb_adr_o,
   output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
   output logic                     wb_we_o,
   output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
   input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
   input  logic                     wb_ack_i,
   input  logic                     wb_err_i,
   input  logic                     wb_rty_i,
   input  logic                     wb_stall_i
);

   localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

   state_e state_q, state_d;

   logic [3:0]               retry_q, retry_d;
   logic                     cyc_q, stb_q;
   logic                     we_q, we_d;
   logic [ADDR_WIDTH-1:0]    adr_q, adr_d;
   logic [WB_SEL_WIDTH-1:0]  sel_q, sel_d;
   logic [WB_DATA_WIDTH-1:0] wdat_q, wdat_d;
   logic [WB_DATA_WIDTH-1:0] rdat_q, rdat_d;
   logic                     rsp_valid_q;
   logic                     rsp_err_q, rsp_err_d;
   logic                     strobe_entry;
   logic                     timeout;

`ifdef WB_MASTER_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   wb_req_watchdog #(
      .WIDTH (WD_W)
   ) u_wd (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .clr_i      (strobe_entry),
      .en_i       (cyc_q),
      .load_i     (1'b0),
      .load_val_i ('0),
      .limit_i    (WD_W'(TIMEOUT_CYCLES)),
      .expired_o  (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      retry_d      = retry_q;
      we_d         = we_q;
      adr_d        = adr_q;
      sel_d        = sel_q;
      wdat_d       = wdat_q;
      rdat_d       = rdat_q;
      rsp_err_d    = rsp_err_q;
      strobe_entry = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               we_d         = req_we_i;
               adr_d        = req_addr_i;
               sel_d        = req_sel_i;
               wdat_d       = req_dat_i;
               retry_d      = 4'd0;
               strobe_entry = 1'b1;
               state_d      = ST_STROBE;
            end
         end
         ST_STROBE, ST_WAIT: begin
            // err beats ack beats rty; any of them beats the watchdog
            if (wb_err_i) begin
               rsp_err_d = 1'b1;
               rdat_d    = '0;
               state_d   = ST_RESP;
            end else if (wb_ack_i) begin
               rsp_err_d = 1'b0;
               rdat_d    = we_q ? '0 : wb_dat_i;
               state_d   = ST_RESP;
            end else if (wb_rty_i && (retry_q < RETRY_LIM)) begin
               retry_d      = retry_q + 4'd1;
               strobe_entry = 1'b1;
               state_d      = ST_STROBE;
            end else if (wb_rty_i || timeout) begin
               rsp_err_d = 1'b1;
               rdat_d    = '0;
               state_d   = ST_RESP;
            end else if ((state_q == ST_STROBE) && !wb_stall_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         retry_q     <= 4'd0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         sel_q       <= '0;
         wdat_q      <= '0;
         rdat_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         retry_q     <= retry_d;
         cyc_q       <= (state_d == ST_STROBE) || (state_d == ST_WAIT);
         stb_q       <= (state_d == ST_STROBE);
         we_q        <= we_d;
         adr_q       <= adr_d;
         sel_q       <= sel_d;
         wdat_q      <= wdat_d;
         rdat_q      <= rdat_d;
         rsp_valid_q <= (state_d == ST_RESP);
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_rdy_o   = (state_q == ST_IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_dat_o   = rdat_q;
   assign rsp_err_o   = rsp_err_q;
   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = stb_q;
   assign wb_adr_o    = adr_q;
   assign wb_sel_o    = sel_q;
   assign wb_we_o     = we_q;
   assign wb_dat_o    = wdat_q;

endmodule

// File: tb/tb_wb_req_master.sv
// Scoreboard bench for wb_req_master with a scripted Wishbone slave.
// Timeout cases run only when WB_MASTER_TIMEOUT_EN is defined.
module tb_wb_req_master;

   localparam logic [2:0] K_RTY = 3'b001;
   localparam logic [2:0] K_ACK = 3'b010;
   localparam logic [2:0] K_ERR = 3'b100;

   typedef struct {
      int          stall;
      int          lat;
      logic [2:0]  kind;
      logic [31:0] dat;
   } slv_t;

   typedef struct {
      logic        err;
      logic [31:0] dat;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        req_i = 1'b0;
   logic        req_we_i = 1'b0;
   logic [7:0]  req_addr_i = 8'h0;
   logic [31:0] req_dat_i = 32'h0;
   logic [3:0]  req_sel_i = 4'h0;
   logic        req_rdy_o;
   logic        rsp_valid_o;
   logic [31:0] rsp_dat_o;
   logic        rsp_err_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic [7:0]  wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i = 32'h0;
   logic        wb_ack_i = 1'b0;
   logic        wb_err_i = 1'b0;
   logic        wb_rty_i = 1'b0;
   logic        wb_stall_i = 1'b0;

   int   n_chk = 0;
   int   n_fail = 0;
   int   n_rsp = 0;
   int   n_stb = 0;
   int   n_stbcyc = 0;
   logic spur = 1'b0;
   logic cyc_gap = 1'b0;

   slv_t slv_q[$];
   exp_t exp_q[$];

   wb_req_master #(
      .ADDR_WIDTH     (8),
      .MAX_RETRY      (3)
`ifdef WB_MASTER_TIMEOUT_EN
      , .TIMEOUT_CYCLES (16)
`endif
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .req_i       (req_i),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_dat_i   (req_dat_i),
      .req_sel_i   (req_sel_i),
      .req_rdy_o   (req_rdy_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_dat_o   (rsp_dat_o),
      .rsp_err_o   (rsp_err_o),
      .wb_cyc_o    (wb_cyc_o),
      .wb_stb_o    (wb_stb_o),
      .wb_adr_o    (wb_adr_o),
      .wb_sel_o    (wb_sel_o),
      .wb_we_o     (wb_we_o),
      .wb_dat_o    (wb_dat_o),
      .wb_dat_i    (wb_dat_i),
      .wb_ack_i    (wb_ack_i),
      .wb_err_i    (wb_err_i),
      .wb_rty_i    (wb_rty_i),
      .wb_stall_i  (wb_stall_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic we, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      int n;
      n = 0;
      req_we_i   = we;
      req_addr_i = a;
      req_dat_i  = d;
      req_sel_i  = s;
      req_i      = 1'b1;
      while (!req_rdy_o && n < 50) begin
         tick;
         n++;
      end
      if (!req_rdy_o) chk("rdy_wait", 32'(req_rdy_o), 32'd1);
      tick;
      req_i = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      do begin
         tick;
         n++;
         if (!rsp_valid_o && !wb_cyc_o) cyc_gap = 1'b1;
      end while (!rsp_valid_o && n < 100);
      if (!rsp_valid_o) chk("rsp_wait", 32'(rsp_valid_o), 32'd1);
   endtask

   // Scripted slave: one entry per strobe (stall cycles, then term lat cycles after accept).
   slv_t        cur;
   int          s_cnt;
   logic        s_act = 1'b0;
   logic [7:0]  s_adr;
   always begin
      @(posedge clk_i);
      #1;
      wb_ack_i   = spur;
      wb_err_i   = spur;
      wb_rty_i   = spur;
      wb_stall_i = 1'b0;
      wb_dat_i   = 32'h0;
      if (!wb_cyc_o) begin
         s_act = 1'b0;
      end else begin
         if (wb_stb_o) n_stbcyc++;
         if (wb_stb_o && !s_act) begin
            s_act = 1'b1;
            s_cnt = 0;
            s_adr = wb_adr_o;
            n_stb++;
            if (slv_q.size() > 0) cur = slv_q.pop_front();
            else cur = '{stall: 0, lat: 100000, kind: 3'b000, dat: 32'h0};
         end
         if (wb_stb_o) chk("adr_stable", 32'(wb_adr_o), 32'(s_adr));
         if (s_act) begin
            if (s_cnt < cur.stall) wb_stall_i = 1'b1;
            if (s_cnt == cur.stall + cur.lat) begin
               wb_err_i = cur.kind[2];
               wb_ack_i = cur.kind[1];
               wb_rty_i = cur.kind[0];
               wb_dat_i = cur.dat;
               s_act    = 1'b0;
            end
            s_cnt++;
         end
      end
   end

   exp_t e;
   always @(negedge clk_i) begin
      if (rst_n_i && rsp_valid_o) begin
         n_rsp++;
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
            chk("rsp_dat", rsp_dat_o, e.dat);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      int s0;
      int r0;

      repeat (3) tick;
      chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("rst_stb", 32'(wb_stb_o), 32'd0);
      chk("rst_we", 32'(wb_we_o), 32'd0);
      chk("rst_adr", 32'(wb_adr_o), 32'd0);
      chk("rst_sel", 32'(wb_sel_o), 32'd0);
      chk("rst_wdat", wb_dat_o, 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
      chk("rst_rsp_dat", rsp_dat_o, 32'd0);
      rst_n_i = 1'b1;
      tick;
      chk("rst_rdy", 32'(req_rdy_o), 32'd1);

      // write, ack 3 cycles after stb
      slv_q.push_back('{stall: 0, lat: 3, kind: K_ACK, dat: 32'hFFFF_FFFF});
      exp_q.push_back('{err: 1'b0, dat: 32'h0});
      s0 = n_stbcyc;
      issue(1'b1, 8'h00, 32'hA5A5_0001, 4'hF);
      chk("wr_cyc", 32'(wb_cyc_o), 32'd1);
      chk("wr_stb", 32'(wb_stb_o), 32'd1);
      chk("wr_we", 32'(wb_we_o), 32'd1);
      chk("wr_adr", 32'(wb_adr_o), 32'h00);
      chk("wr_dat", wb_dat_o, 32'hA5A5_0001);
      chk("wr_sel", 32'(wb_sel_o), 32'hF);
      wait_rsp(n);
      chk("wr_lat", 32'(n), 32'd4);
      chk("wr_stb_cycles", 32'(n_stbcyc - s0), 32'd1);
      chk("wr_rsp_cyc", 32'(wb_cyc_o), 32'd0);
      tick;
      chk("wr_pulse_len", 32'(rsp_valid_o), 32'd0);
      chk("wr_rdy", 32'(req_rdy_o), 32'd1);

      // read with 2 stall cycles
      slv_q.push_back('{stall: 2, lat: 0, kind: K_ACK, dat: 32'h1234_5678});
      exp_q.push_back('{err: 1'b0, dat: 32'h1234_5678});
      s0 = n_stbcyc;
      issue(1'b0, 8'h3C, 32'h0, 4'h3);
      chk("rd_we", 32'(wb_we_o), 32'd0);
      chk("rd_adr", 32'(wb_adr_o), 32'h3C);
      wait_rsp(n);
      chk("rd_lat", 32'(n), 32'd3);
      chk("rd_stb_cycles", 32'(n_stbcyc - s0), 32'd3);
      tick;
      chk("rd_hold_dat", rsp_dat_o, 32'h1234_5678);

      // retry exhaustion
      repeat (4) slv_q.push_back('{stall: 0, lat: 0, kind: K_RTY, dat: 32'h0});
      exp_q.push_back('{err: 1'b1, dat: 32'h0});
      s0 = n_stb;
      cyc_gap = 1'b0;
      issue(1'b1, 8'h80, 32'h0BAD_0BAD, 4'h1);
      wait_rsp(n);
      chk("rty_lat", 32'(n), 32'd4);
      chk("rty_strobes", 32'(n_stb - s0), 32'd4);
      chk("rty_cyc_held", 32'(cyc_gap), 32'd0);
      tick;

      // spurious terminations while idle
      r0 = n_rsp;
      spur = 1'b1;
      repeat (3) tick;
      spur = 1'b0;
      tick;
      chk("spur_cyc", 32'(wb_cyc_o), 32'd0);
      chk("spur_rsp", 32'(n_rsp - r0), 32'd0);
      chk("spur_rdy", 32'(req_rdy_o), 32'd1);

      // ack+err together, req_i held for back-to-back
      slv_q.push_back('{stall: 0, lat: 0, kind: K_ACK | K_ERR, dat: 32'hDEAD_BEEF});
      exp_q.push_back('{err: 1'b1, dat: 32'h0});
      slv_q.push_back('{stall: 0, lat: 1, kind: K_ACK, dat: 32'hCAFE_F00D});
      exp_q.push_back('{err: 1'b0, dat: 32'hCAFE_F00D});
      req_we_i   = 1'b0;
      req_addr_i = 8'h11;
      req_sel_i  = 4'hF;
      req_i      = 1'b1;
      tick;
      req_addr_i = 8'h22;
      wait_rsp(n);
      chk("ae_lat", 32'(n), 32'd1);
      tick;
      chk("b2b_rdy", 32'(req_rdy_o), 32'd1);
      tick;
      req_i = 1'b0;
      chk("b2b_cyc", 32'(wb_cyc_o), 32'd1);
      chk("b2b_adr", 32'(wb_adr_o), 32'h22);
      wait_rsp(n);
      chk("b2b_lat", 32'(n), 32'd2);
      tick;

`ifdef WB_MASTER_TIMEOUT_EN
      // slave never answers
      exp_q.push_back('{err: 1'b1, dat: 32'h0});
      cyc_gap = 1'b0;
      issue(1'b0, 8'h44, 32'h0, 4'hF);
      wait_rsp(n);
      chk("to_lat", 32'(n), 32'd17);
      chk("to_cyc_held", 32'(cyc_gap), 32'd0);
      chk("to_cyc_drop", 32'(wb_cyc_o), 32'd0);
      r0 = n_rsp;
      spur = 1'b1;
      repeat (3) tick;
      spur = 1'b0;
      tick;
      chk("to_late_ack", 32'(n_rsp - r0), 32'd0);
      chk("to_rdy", 32'(req_rdy_o), 32'd1);
`endif

      // reset while in WAIT
      slv_q.push_back('{stall: 0, lat: 1000, kind: K_ACK, dat: 32'h0});
      issue(1'b0, 8'h55, 32'h0, 4'hF);
      tick;
      chk("wait_stb", 32'(wb_stb_o), 32'd0);
      chk("wait_cyc", 32'(wb_cyc_o), 32'd1);
      r0 = n_rsp;
      rst_n_i = 1'b0;
      #1;
      chk("arst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("arst_stb", 32'(wb_stb_o), 32'd0);
      repeat (2) tick;
      rst_n_i = 1'b1;
      tick;
      chk("arst_rdy", 32'(req_rdy_o), 32'd1);
      chk("arst_valid", 32'(rsp_valid_o), 32'd0);
      repeat (3) tick;
      chk("arst_no_rsp", 32'(n_rsp - r0), 32'd0);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      chk("slv_empty", 32'(slv_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
